// File: rtl/serial_to_parallel_32_bit.sv
// Serial-to-parallel word assembler with framing, stall and restart support.
// Optional even-parity check when SERIAL_PARITY_CHECK_EN is defined.
module serial_to_parallel_32_bit #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Serial_In,
  input  logic             Serial_Valid,
  input  logic             Frame_Start,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Word_Valid,
  output logic             Busy,
  output logic             Frame_Error,
  output logic             Parity_Error
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wv_q, wv_d;
  logic             fe_q, fe_d;
`ifdef SERIAL_PARITY_CHECK_EN
  logic             par_q, par_d;
  logic             pe_q, pe_d;
`endif

  logic [WIDTH-1:0] first_w;
  logic [WIDTH-1:0] shift_w;
  logic             last_bit;

  // Bit 0 of a frame sits where a full frame of shifts will carry it.
  assign first_w  = MSB_FIRST ? {{(WIDTH-1){1'b0}}, Serial_In}
                              : {Serial_In, {(WIDTH-1){1'b0}}};
  assign shift_w  = MSB_FIRST ? {sr_q[WIDTH-2:0], Serial_In}
                              : {Serial_In, sr_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH-1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    wv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif
    if (Serial_Valid) begin
      if (Frame_Start) begin
        fe_d    = (state_q != IDLE);
        state_d = SHIFT;
        cnt_d   = CW'(1);
        sr_d    = first_w;
`ifdef SERIAL_PARITY_CHECK_EN
        par_d   = Serial_In;
`endif
      end else begin
        unique case (state_q)
          IDLE: begin
            state_d = IDLE;
          end
          SHIFT: begin
            sr_d = shift_w;
`ifdef SERIAL_PARITY_CHECK_EN
            par_d = par_q ^ Serial_In;
`endif
            if (last_bit) begin
              cnt_d = '0;
`ifdef SERIAL_PARITY_CHECK_EN
              state_d = PARITY;
`else
              state_d = IDLE;
              dout_d  = shift_w;
              wv_d    = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          PARITY: begin
            state_d = IDLE;
`ifdef SERIAL_PARITY_CHECK_EN
            if (par_q ^ Serial_In) begin
              pe_d = 1'b1;
            end else begin
              dout_d = sr_q;
              wv_d   = 1'b1;
            end
`endif
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      wv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      wv_q    <= wv_d;
      fe_q    <= fe_d;
`ifdef SERIAL_PARITY_CHECK_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign Data_Out    = dout_q;
  assign Word_Valid  = wv_q;
  assign Frame_Error = fe_q;
  assign Busy        = (state_q != IDLE);
`ifdef SERIAL_PARITY_CHECK_EN
  assign Parity_Error = pe_q;
`else
  assign Parity_Error = 1'b0;
`endif

endmodule
